// File: rtl/interleaver_bank_scheduler_pkg.sv
`default_nettype none
//==============================================================================
// interleaver_bank_scheduler_pkg -- bank-state encoding and default block sizes
// Rev 1.0
//==============================================================================
package interleaver_bank_scheduler_pkg;

    localparam int c_k_small = 1056;
    localparam int c_k_large = 6144;
    localparam int c_aw      = 13;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/interleaver_bank_ctr.sv
`default_nettype none
//==============================================================================
// interleaver_bank_ctr -- per-bank address counter, terminal count set by blocksize
// Rev 1.0
//==============================================================================
module interleaver_bank_ctr
    import interleaver_bank_scheduler_pkg::*;
#(
    parameter int K_SMALL = c_k_small,
    parameter int K_LARGE = c_k_large,
    parameter int AW      = c_aw
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic          i_blocksize,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    localparam logic [AW-1:0] c_last_small = AW'(K_SMALL - 1);
    localparam logic [AW-1:0] c_last_large = AW'(K_LARGE - 1);

    logic [AW-1:0] r_addr;
    logic          w_last;

    assign w_last = (r_addr == (i_blocksize ? c_last_large : c_last_small));

    // Holds at the terminal count; the owner clears it when the bank changes phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_inc && !w_last) begin
            r_addr <= r_addr + AW'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/interleaver_bank_scheduler.sv
`default_nettype none
//==============================================================================
// interleaver_bank_scheduler -- ping-pong bank write/read sequencing for an interleaver
// Rev 1.0
//==============================================================================
module interleaver_bank_scheduler
    import interleaver_bank_scheduler_pkg::*;
#(
    parameter int K_SMALL = c_k_small,
    parameter int K_LARGE = c_k_large,
    parameter int AW      = c_aw
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          CRC_start,
    input  logic          CRC_blocksize,
    input  logic          CRC_end,
    input  logic          out_ready,
    input  logic          err_clr,
    output logic          in_ready,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          rd_blocksize,
    output logic          rd_valid,
    output logic          block_done,
    output logic [1:0]    bank_full,
    output logic          len_err,
    output logic          ovf_err
);

    logic r_wr_ptr;
    logic r_rd_ptr;
    logic r_in_ready;
    logic r_rd_valid;
    logic r_len_err;
    logic r_ovf_err;

    logic [1:0]         w_is_empty;
    logic [1:0]         w_is_filling;
    logic [1:0]         w_is_full;
    logic [1:0]         w_is_draining;
    logic [1:0]         w_last;
    logic [1:0]         w_bs;
    logic [1:0][AW-1:0] w_addr;

    logic w_start_acc;
    logic w_wr_active;
    logic w_wr_ok;
    logic w_wr_bad;
    logic w_rd_en;
    logic w_rd_done;

    assign w_start_acc = CRC_start & r_in_ready;
    assign w_wr_active = w_start_acc | w_is_filling[r_wr_ptr];
    assign w_wr_ok     = w_wr_active & CRC_end & w_last[r_wr_ptr];
    // Either an early CRC_end or reaching the terminal address without one.
    assign w_wr_bad    = w_wr_active & (CRC_end ^ w_last[r_wr_ptr]);
    assign w_rd_en     = w_is_draining[r_rd_ptr] & out_ready;
    assign w_rd_done   = w_rd_en & w_last[r_rd_ptr];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic c_idx = 1'(gi);

        bank_state_t r_state;
        bank_state_t w_state_nxt;
        logic        r_bs;
        logic        w_wr_sel;
        logic        w_rd_sel;
        logic        w_ctr_bs;
        logic        w_clr;
        logic        w_inc;

        assign w_wr_sel = w_wr_active & (r_wr_ptr == c_idx);
        assign w_rd_sel = (r_rd_ptr == c_idx);
        // The blocksize is not latched yet in the start cycle, so use the live input.
        assign w_ctr_bs = (w_wr_sel & w_start_acc) ? CRC_blocksize : r_bs;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= BANK_EMPTY;
                r_bs    <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (w_wr_sel && w_start_acc) begin
                    r_bs <= CRC_blocksize;
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_clr       = 1'b0;
            w_inc       = 1'b0;
            if (w_wr_sel) begin
                if (w_wr_ok) begin
                    w_state_nxt = BANK_FULL;
                    w_clr       = 1'b1;
                end else if (w_wr_bad) begin
                    w_state_nxt = BANK_EMPTY;
                    w_clr       = 1'b1;
                end else begin
                    w_state_nxt = BANK_FILLING;
                    w_inc       = 1'b1;
                end
            end else if (w_rd_sel) begin
                case (r_state)
                    BANK_FULL: begin
                        w_state_nxt = BANK_DRAINING;
                    end
                    BANK_DRAINING: begin
                        if (w_rd_done) begin
                            w_state_nxt = BANK_EMPTY;
                            w_clr       = 1'b1;
                        end else if (w_rd_en) begin
                            w_inc = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        interleaver_bank_ctr #(
            .K_SMALL (K_SMALL),
            .K_LARGE (K_LARGE),
            .AW      (AW)
        ) u_ctr (
            .clk         (clk),
            .reset       (reset),
            .i_clr       (w_clr),
            .i_inc       (w_inc),
            .i_blocksize (w_ctr_bs),
            .o_addr      (w_addr[gi]),
            .o_last      (w_last[gi])
        );

        assign w_is_empty[gi]    = (r_state == BANK_EMPTY);
        assign w_is_filling[gi]  = (r_state == BANK_FILLING);
        assign w_is_full[gi]     = (r_state == BANK_FULL);
        assign w_is_draining[gi] = (r_state == BANK_DRAINING);
        assign w_bs[gi]          = r_bs;
    end

    // in_ready looks at the current bank state, so a freshly emptied bank opens one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_len_err  <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_rd_done) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_in_ready <= w_is_empty[r_wr_ptr] & ~w_start_acc;
            r_rd_valid <= w_rd_en;
            if (w_wr_bad) begin
                r_len_err <= 1'b1;
            end else if (err_clr) begin
                r_len_err <= 1'b0;
            end
            if (CRC_start && !r_in_ready) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign wr_en        = w_wr_active;
    assign wr_bank      = r_wr_ptr;
    assign wr_addr      = w_addr[r_wr_ptr];
    assign rd_en        = w_rd_en;
    assign rd_bank      = r_rd_ptr;
    assign rd_addr      = w_addr[r_rd_ptr];
    assign rd_blocksize = w_bs[r_rd_ptr];
    assign rd_valid     = r_rd_valid;
    assign block_done   = w_rd_done;
    assign bank_full    = w_is_full | w_is_draining;
    assign len_err      = r_len_err;
    assign ovf_err      = r_ovf_err;

endmodule
`default_nettype wire
